// File: rtl/fios_res_collector_pkg.sv
// Shared definitions for the FIOS result collector: word width and FSM state encoding.
package fios_pkg;

    localparam int unsigned WORD_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } res_col_state_t;

endpackage

// File: rtl/fios_res_collector_if.sv
// RES input stream and reduced-result output stream of the FIOS collector.
interface fios_res_collector_if;
    import fios_pkg::*;

    logic              res_valid_i;
    logic              res_first_i;
    logic [WORD_W-1:0] res_i;
    logic [WORD_W-1:0] p_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WORD_W-1:0] out_data_o;
    logic              out_last_o;

    modport master (
        output res_valid_i, res_first_i, res_i, p_i, out_ready_i,
        input  out_valid_o, out_data_o, out_last_o
    );

    modport slave (
        input  res_valid_i, res_first_i, res_i, p_i, out_ready_i,
        output out_valid_o, out_data_o, out_last_o
    );

endinterface

// File: rtl/fios_res_collector_buffer.sv
// s x W register file: one synchronous write port, one asynchronous read port.
module res_word_buffer #(
    parameter int unsigned s = 8,
    parameter int unsigned W = 17
) (
    input  logic                                 clock_i,
    input  logic                                 we,
    input  logic [((s > 1) ? $clog2(s) : 1)-1:0] waddr,
    input  logic [W-1:0]                         wdata,
    input  logic [((s > 1) ? $clog2(s) : 1)-1:0] raddr,
    output logic [W-1:0]                         rdata
);

    logic [W-1:0] mem [s];

    always_ff @(posedge clock_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fios_res_collector.sv
// Collects the word-serial FIOS RES stream, applies the final R >= p ? R-p : R
// reduction with a serial borrow chain, and replays the result as a valid/ready stream.
module fios_res_collector
    import fios_pkg::*;
#(
    parameter int unsigned s = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    fios_res_collector_if.slave  bus,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned W     = WORD_W;
    localparam int unsigned IDX_W = (s > 1) ? $clog2(s) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(s - 1);

    res_col_state_t   state, state_n;
    logic [IDX_W-1:0] idx, idx_n, wr_idx;
    logic             borrow, borrow_n, borrow_in;
    logic             sel_sub, sel_sub_n;
    logic             err, err_n;
    logic             capture;
    logic [W:0]       diff;
    logic [W-1:0]     r_rd, d_rd;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            idx     <= '0;
            borrow  <= 1'b0;
            sel_sub <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            borrow  <= borrow_n;
            sel_sub <= sel_sub_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        borrow_n  = borrow;
        sel_sub_n = sel_sub;
        err_n     = err;
        capture   = 1'b0;
        wr_idx    = idx;
        borrow_in = borrow;

        case (state)
            IDLE: begin
                if (bus.res_valid_i) begin
                    if (bus.res_first_i) begin
                        capture   = 1'b1;
                        wr_idx    = '0;
                        borrow_in = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.res_valid_i) begin
                    capture = 1'b1;
                    if (bus.res_first_i) begin
                        err_n     = 1'b1;
                        wr_idx    = '0;
                        borrow_in = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (bus.res_valid_i) begin
                    err_n = 1'b1;
                end
                if (bus.out_ready_i) begin
                    if (idx == LAST) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase

        diff = {1'b0, bus.res_i} - {1'b0, bus.p_i} - {{W{1'b0}}, borrow_in};

        // Word 0 and the final word share this path, so a restart or s==1 lands correctly.
        if (capture) begin
            borrow_n = diff[W];
            if (wr_idx == LAST) begin
                sel_sub_n = ~diff[W];
                idx_n     = '0;
                state_n   = DRAIN;
            end else begin
                idx_n   = wr_idx + IDX_W'(1);
                state_n = COLLECT;
            end
        end
    end

    res_word_buffer #(.s(s), .W(W)) u_r_buf (
        .clock_i (clock_i),
        .we      (capture),
        .waddr   (wr_idx),
        .wdata   (bus.res_i),
        .raddr   (idx),
        .rdata   (r_rd)
    );

    res_word_buffer #(.s(s), .W(W)) u_d_buf (
        .clock_i (clock_i),
        .we      (capture),
        .waddr   (wr_idx),
        .wdata   (diff[W-1:0]),
        .raddr   (idx),
        .rdata   (d_rd)
    );

    // Data is gated by state so stale buffer contents never leave the block after reset.
    assign bus.out_valid_o = (state == DRAIN);
    assign bus.out_data_o  = (state == DRAIN) ? (sel_sub ? d_rd : r_rd) : '0;
    assign bus.out_last_o  = (state == DRAIN) && (idx == LAST);
    assign busy_o          = (state != IDLE);
    assign err_o           = err;

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector with s=2 and p = {0x00001, 0x00003}.
module tb_fios_res_collector;
    import fios_pkg::*;

    localparam logic [16:0] P_LO = 17'h00003;
    localparam logic [16:0] P_HI = 17'h00001;

    logic clk;
    logic rst_n;
    logic busy;
    logic err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [17:0] exp_q [$];

    fios_res_collector_if bus ();

    fios_res_collector #(.s(2)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus.slave),
        .busy_o    (busy),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every accepted output word.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got data=%05h last=%0b, required no output",
                         bus.out_data_o, bus.out_last_o);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({bus.out_data_o, bus.out_last_o} !== e) begin
                    errors++;
                    $display("FAIL out_word: got data=%05h last=%0b, required data=%05h last=%0b",
                             bus.out_data_o, bus.out_last_o, e[17:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_word(input logic first, input logic [16:0] r, input logic [16:0] p);
        @(posedge clk); #1;
        bus.res_valid_i = 1'b1;
        bus.res_first_i = first;
        bus.res_i       = r;
        bus.p_i         = p;
        @(posedge clk); #1;
        bus.res_valid_i = 1'b0;
        bus.res_first_i = 1'b0;
    endtask

    task automatic send(input logic [16:0] hi, input logic [16:0] lo, input bit push,
                        input logic [16:0] e0, input logic [16:0] e1);
        if (push) begin
            exp_q.push_back({e0, 1'b0});
            exp_q.push_back({e1, 1'b1});
        end
        drive_word(1'b1, lo, P_LO);
        drive_word(1'b0, hi, P_HI);
    endtask

    task automatic wait_idle(input string name);
        int unsigned n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles, required busy=0", name, n);
        end
    endtask

    initial begin
        bus.res_valid_i = 1'b0;
        bus.res_first_i = 1'b0;
        bus.res_i       = '0;
        bus.p_i         = '0;
        bus.out_ready_i = 1'b1;
        rst_n           = 1'b0;
        #12;
        check("reset_valid", 32'(bus.out_valid_o), 32'd0);
        check("reset_data",  32'(bus.out_data_o),  32'd0);
        check("reset_last",  32'(bus.out_last_o),  32'd0);
        check("reset_busy",  32'(busy),            32'd0);
        check("reset_err",   32'(err),             32'd0);
        rst_n = 1'b1;

        send(17'h00001, 17'h00005, 1'b1, 17'h00002, 17'h00000);
        wait_idle("r_gt_p");
        send(17'h00001, 17'h00002, 1'b1, 17'h00002, 17'h00001);
        wait_idle("r_lt_p");
        send(17'h00001, 17'h00003, 1'b1, 17'h00000, 17'h00000);
        wait_idle("r_eq_p");
        send(17'h00002, 17'h00000, 1'b1, 17'h1FFFD, 17'h00000);
        wait_idle("borrow");
        check("no_err_clean", 32'(err), 32'd0);

        // Backpressure: hold word 0 for three cycles.
        bus.out_ready_i = 1'b0;
        send(17'h00001, 17'h00005, 1'b1, 17'h00002, 17'h00000);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(bus.out_valid_o), 32'd1);
            check("bp_data",  32'(bus.out_data_o),  32'h00002);
            check("bp_last",  32'(bus.out_last_o),  32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_busy_mid", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("bp_busy_done", 32'(busy), 32'd0);
        check("bp_valid_done", 32'(bus.out_valid_o), 32'd0);

        // Word without first in IDLE is dropped and flags an error.
        drive_word(1'b0, 17'h00005, P_LO);
        drive_word(1'b0, 17'h00001, P_HI);
        check("idle_err", 32'(err), 32'd1);
        check("idle_drop_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(err), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Restart mid-COLLECT: second first-word replaces the first.
        exp_q.push_back({17'h00002, 1'b0});
        exp_q.push_back({17'h00001, 1'b1});
        drive_word(1'b1, 17'h00005, P_LO);
        drive_word(1'b1, 17'h00002, P_LO);
        drive_word(1'b0, 17'h00001, P_HI);
        wait_idle("restart");
        check("restart_err", 32'(err), 32'd1);

        // Reset mid-COLLECT.
        drive_word(1'b1, 17'h00005, P_LO);
        check("mc_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mc_rst_busy",  32'(busy),            32'd0);
        check("mc_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("mc_rst_err",   32'(err),             32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Reset mid-DRAIN.
        bus.out_ready_i = 1'b0;
        send(17'h00002, 17'h00000, 1'b0, 17'h0, 17'h0);
        check("md_valid", 32'(bus.out_valid_o), 32'd1);
        check("md_data",  32'(bus.out_data_o),  32'h1FFFD);
        #1;
        rst_n = 1'b0;
        #1;
        check("md_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("md_rst_data",  32'(bus.out_data_o),  32'd0);
        check("md_rst_last",  32'(bus.out_last_o),  32'd0);
        check("md_rst_busy",  32'(busy),            32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;

        send(17'h00001, 17'h00002, 1'b1, 17'h00002, 17'h00001);
        wait_idle("post_reset");
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
